// File: rtl/fir_pkg.sv
// Shared parameters, FSM encoding, default coefficients and saturation limits
// for the serial 8-tap FIR sequencer.
package fir_pkg;

    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int FRAC = 12;
    localparam int ACCW = 36;
    localparam int AW   = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [DW-1:0] DEF_COEF [TAPS] = '{
        16'hFEA8, 16'hFF18, 16'h02EC, 16'h068A,
        16'h068A, 16'h02EC, 16'hFF18, 16'hFEA8
    };

    localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2 ** (DW - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN  = ACCW'(-(2 ** (DW - 1)));
    localparam logic signed [ACCW-1:0] HALF_LSB = ACCW'(2 ** (FRAC - 1));

endpackage

// File: rtl/fir_mac.sv
// Signed DW x DW multiply with sign-extended accumulation and synchronous clear.
module fir_mac
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACCW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial 8-tap FIR: ring-buffer delay line, programmable coefficient bank and
// one shared MAC, with round-half-up and saturation back to Q4.12.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_wdata,
    output logic          coef_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y_out,
    output logic          sat_flag,
    output logic          busy
);

    state_t        state_q;
    logic [DW-1:0] ring_q [TAPS];
    logic [DW-1:0] coef_q [TAPS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] k_q;
    logic [DW-1:0] y_q;
    logic          sat_q;
    logic          out_valid_q;
    logic          coef_err_q;

    logic                   addr_ok;
    logic                   coef_apply;
    logic [AW-1:0]          tap_idx;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] rounded;
    logic [DW-1:0]          y_d;
    logic                   sat_d;

    assign addr_ok    = (32'(coef_addr) < TAPS);
    assign coef_apply = coef_we && addr_ok && (state_q == IDLE);

    // TAPS is a power of two, so the AW-bit subtraction is the modulo-TAPS walk
    // backwards through the delay line from the newest sample.
    assign tap_idx = base_q - k_q;

    fir_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == IDLE),
        .en_i  (state_q == MAC),
        .a_i   (coef_q[k_q]),
        .b_i   (ring_q[tap_idx]),
        .acc_o (acc)
    );

    assign rounded = (acc + HALF_LSB) >>> FRAC;

    always_comb begin
        y_d   = rounded[DW-1:0];
        sat_d = 1'b0;
        if (rounded > SAT_MAX) begin
            y_d   = SAT_MAX[DW-1:0];
            sat_d = 1'b1;
        end else if (rounded < SAT_MIN) begin
            y_d   = SAT_MIN[DW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                ring_q[i] <= '0;
                coef_q[i] <= DEF_COEF[i];
            end
        end else begin
            coef_err_q <= coef_we && !coef_apply;
            if (coef_apply) begin
                coef_q[coef_addr] <= coef_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ring_q[wr_ptr_q] <= x_in;
                        base_q           <= wr_ptr_q;
                        wr_ptr_q         <= wr_ptr_q + 1'b1;
                        k_q              <= '0;
                        state_q          <= MAC;
                    end
                end
                MAC: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == AW'(TAPS - 1)) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    y_q         <= y_d;
                    sat_q       <= sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign sat_flag  = sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised scoreboard bench for fir_mac_sequencer against a sample-history
// reference model of the 8-tap FIR with round-half-up and saturation.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        coef_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] y_out;
    logic        sat_flag;
    logic        busy;

    typedef struct packed {
        logic [15:0] y;
        logic        sat;
    } exp_t;

    localparam int DEFAULTS [8] = '{-344, -232, 748, 1674, 1674, 748, -232, -344};

    exp_t   sbQ[$];
    int     hist[$];
    int     coefM [8];
    int     checks = 0;
    int     failures = 0;
    int     readyMode = 0;
    longint lastAcceptTime = 0;
    logic [15:0] lastY = '0;
    logic        lastSat = 1'b0;

    fir_mac_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .sat_flag   (sat_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: y[n] = sum_k coef[k] * x[n-k], samples older than reset are zero.
    function automatic exp_t predict();
        exp_t   e;
        longint acc = 0;
        longint r;
        for (int k = 0; k < 8; k++) begin
            if (k < hist.size()) acc += longint'(coefM[k]) * longint'(hist[k]);
        end
        r = (acc + 2048) >>> 12;
        if (r > 32767) begin
            e.y = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.y = 16'h8000; e.sat = 1'b1;
        end else begin
            e.y = 16'(r); e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic void modelReset();
        hist.delete();
        sbQ.delete();
        for (int i = 0; i < 8; i++) coefM[i] = DEFAULTS[i];
    endfunction

    function automatic void modelAccept(input logic [15:0] x);
        hist.push_front(int'($signed(x)));
        if (hist.size() > 8) void'(hist.pop_back());
        sbQ.push_back(predict());
    endfunction

    function automatic void modelWrite(input int addr, input logic [15:0] v);
        coefM[addr] = int'($signed(v));
    endfunction

    // Offers one sample; an optional coefficient write rides the accepting edge.
    task automatic applyStimulus(input logic [15:0] x, input bit doWrite, input int addr, input logic [15:0] val);
        int guard = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        x_in     = x;
        while (guard < 300) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            guard++;
        end
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (doWrite) begin
                coef_we    = 1'b1;
                coef_addr  = 3'(addr);
                coef_wdata = val;
            end
            @(posedge clk);
            if (doWrite) modelWrite(addr, val);
            modelAccept(x);
            lastAcceptTime = $time;
            #1;
            in_valid = 1'b0;
            coef_we  = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sbQ.size() != 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (sbQ.size() != 0) checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic writeIdle(input int addr, input logic [15:0] val);
        coef_we    = 1'b1;
        coef_addr  = 3'(addr);
        coef_wdata = val;
        @(posedge clk);
        modelWrite(addr, val);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_y_out"},     32'(y_out),     32'd0);
        checkOutput({tag, "_sat_flag"},  32'(sat_flag),  32'd0);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_coef_err"},  32'(coef_err),  32'd0);
    endtask

    // Monitor: every output handshake pops one expectation from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin : pop_blk
                exp_t e;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("y_out", 32'(y_out), 32'(e.y));
                    checkOutput("sat_flag", 32'(sat_flag), 32'(e.sat));
                    lastY   = y_out;
                    lastSat = sat_flag;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int n;
        longint t0;
        real gain;
        int golden;
        int diff;

        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] impulse response");
        applyStimulus(16'h1000, 1'b0, 0, '0);
        repeat (8) applyStimulus(16'h0000, 1'b0, 0, '0);
        drain();

        $display("[TB] latency and sample period");
        applyStimulus(16'h0321, 1'b0, 0, '0);
        t0 = lastAcceptTime;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid === 1'b1) break;
        end
        checkOutput("valid_latency", 32'(n), 32'd9);
        applyStimulus(16'hF123, 1'b0, 0, '0);
        checkOutput("sample_period", 32'((lastAcceptTime - t0) / 10), 32'd11);
        drain();

        $display("[TB] DC gain");
        repeat (12) applyStimulus(16'h1000, 1'b0, 0, '0);
        drain();
        gain = 0.0;
        for (int i = 0; i < 8; i++) gain += real'(DEFAULTS[i]) / 4096.0;
        golden = $rtoi(gain * 4096.0 + 0.5);
        diff = int'($signed(lastY)) - golden;
        checkOutput("dc_gain_golden", 32'(diff >= -1 && diff <= 1), 32'd1);
        checkOutput("dc_gain_value", 32'(lastY), 32'h0E6C);

        $display("[TB] saturation");
        for (int i = 0; i < 8; i++) writeIdle(i, 16'h1000);
        repeat (8) applyStimulus(16'h7FFF, 1'b0, 0, '0);
        drain();
        checkOutput("sat_pos_y", 32'(lastY), 32'h7FFF);
        checkOutput("sat_pos_flag", 32'(lastSat), 32'd1);
        repeat (8) applyStimulus(16'h8000, 1'b0, 0, '0);
        drain();
        checkOutput("sat_neg_y", 32'(lastY), 32'h8000);
        checkOutput("sat_neg_flag", 32'(lastSat), 32'd1);

        $display("[TB] backpressure");
        readyMode = 2;
        out_ready = 1'b0;
        applyStimulus(16'($urandom), 1'b0, 0, '0);
        n = 0;
        while (n < 30 && out_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (20) begin
            @(negedge clk);
            if (sbQ.size() > 0) checkOutput("bp_y_stable", 32'(y_out), 32'(sbQ[0].y));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        readyMode = 0;
        drain();

        $display("[TB] coefficient write during MAC");
        applyStimulus(16'h0800, 1'b0, 0, '0);
        coef_we    = 1'b1;
        coef_addr  = 3'd3;
        coef_wdata = 16'h0400;
        @(posedge clk);
        #1 coef_we = 1'b0;
        checkOutput("coef_err_pulse", 32'(coef_err), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("coef_err_clear", 32'(coef_err), 32'd0);
        drain();
        writeIdle(3, 16'h0400);
        checkOutput("coef_err_idle", 32'(coef_err), 32'd0);
        applyStimulus(16'h0800, 1'b0, 0, '0);
        applyStimulus(16'h0C00, 1'b1, 5, 16'hE000);
        applyStimulus(16'h0100, 1'b0, 0, '0);
        drain();

        $display("[TB] reset mid-MAC");
        applyStimulus(16'h1234, 1'b0, 0, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        modelReset();
        #1;
        checkResetValues("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(16'h1000, 1'b0, 0, '0);
        repeat (8) applyStimulus(16'h0000, 1'b0, 0, '0);
        drain();

        $display("[TB] randomised traffic");
        readyMode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                drain();
                writeIdle(int'($urandom_range(0, 7)), 16'($urandom));
            end
            applyStimulus(16'($urandom), ($urandom_range(0, 5) == 0),
                          int'($urandom_range(0, 7)), 16'($urandom));
        end
        drain();
        readyMode = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencer for a serial 8-tap FIR: holds the sample delay line and a programmable coefficient bank, and time-shares one 16×16 multiplier-accumulator across all taps. It accepts Q4.12 samples over a valid/ready handshake and returns one Q4.12 filtered result per sample. It sits between the sample source and the output consumer as the area-reduced alternative to the fully parallel `fir_filter`.

## Interface

- `TAPS`, 8, number of taps; also the ring-buffer depth.
- `DW`, 16, sample and coefficient width, signed Q4.12.
- `FRAC`, 12, fractional bits.
- `ACCW`, 36, accumulator width; must be at least 2·DW + clog2(TAPS).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  clog2(TAPS)  coefficient index.
- `coef_wdata`  in  DW  coefficient value, signed Q4.12.
- `coef_err`  out  1  one-cycle pulse when a write is dropped.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sequencer can accept a sample.
- `x_in`  in  DW  signed Q4.12 sample.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `y_out`  out  DW  signed Q4.12 result.
- `sat_flag`  out  1  `y_out` was clipped; qualified by `out_valid`.
- `busy`  out  1  high in MAC, ROUND and OUT.

## Operation

- FSM states and transitions:
  - IDLE → MAC on an input handshake.
  - MAC → ROUND after TAPS cycles.
  - ROUND → OUT.
  - OUT → IDLE on an output handshake.
- `in_ready` = (state == IDLE). `busy` = !IDLE.
- **Accept edge:**
  - `ring[wr_ptr]` ← `x_in`.
  - `base` ← `wr_ptr`.
  - `wr_ptr` ← (`wr_ptr` + 1) mod TAPS.
  - `acc` ← 0 and `k` ← 0.
- **MAC, cycle k = 0..TAPS-1:**
  - `acc` += `coef[k]` × `ring[(base − k) mod TAPS]`.
  - Product is a full 2·DW signed value, sign-extended to ACCW.
  - No wrap within ACCW.
- **ROUND:**
  - `r` = (`acc` + 2^(FRAC−1)) >>> FRAC, arithmetic shift, round half up.
  - If `r` > 0x7FFF: `y_out` = 0x7FFF and `sat_flag` = 1.
  - If `r` < −0x8000: `y_out` = 0x8000 and `sat_flag` = 1.
  - Otherwise `y_out` = `r[DW-1:0]` and `sat_flag` = 0.
  - `y_out`, `sat_flag` and `out_valid` register together on the ROUND edge.
- **OUT:**
  - `y_out` and `sat_flag` hold stable while `out_valid` = 1.
  - `out_valid` drops on the handshake edge.
- **Coefficient writes:**
  - Applied only when state == IDLE; the new value is used by the next sample.
  - A write in any other state is dropped, and `coef_err` pulses on the next cycle.
  - `coef_addr` ≥ TAPS is dropped with the same `coef_err` pulse.
- `in_valid` while not ready is ignored; the source holds it.
- **Reset (any time, including mid-MAC):**
  - In-flight sample discarded; state = IDLE.
  - `ring` and `wr_ptr` cleared to 0.
  - `coef` loaded with package defaults: 0xFEA8, 0xFF18, 0x02EC, 0x068A, 0x068A, 0x02EC, 0xFF18, 0xFEA8.
- Output values during reset: `in_ready` 1, `out_valid` 0, `y_out` 0, `sat_flag` 0, `busy` 0, `coef_err` 0.

## Timing

- Accept at edge E0; MAC on E1..E_TAPS; ROUND on E_(TAPS+1).
- `out_valid` is first high after E_(TAPS+1), i.e. 9 edges after accept for TAPS = 8.
- With `out_ready` held 1: output handshake at E_(TAPS+2), next accept at E_(TAPS+3). Sustained rate is 1 sample per TAPS+3 = 11 cycles.
- Backpressure: `out_ready` low stalls in OUT indefinitely; `in_ready` stays 0.
- Coefficient write and input handshake on the same IDLE edge: the write is applied and the accepted sample uses the new value.

## Structure

- Package `fir_pkg` holds:
  - TAPS, DW, FRAC, ACCW.
  - FSM state enum: IDLE, MAC, ROUND, OUT.
  - Default coefficient array.
  - Saturation limits.
- Sub-module `fir_mac`: signed multiply, sign-extend and accumulate with synchronous clear. The FSM, ring buffer, coefficient bank and rounding stay in the top level.

## Test plan

- **Impulse response:** reset, then feed 0x1000 followed by zeros, `out_ready` = 1. First 8 `y_out` = 0xFEA8, 0xFF18, 0x02EC, 0x068A, 0x068A, 0x02EC, 0xFF18, 0xFEA8, then 0.
- **DC gain:** feed 0x1000 continuously. From the 8th output onward, `y_out` = 0x0E6C and `sat_flag` = 0. Check against a real-valued golden model within ±1 LSB.
- **Saturation:**
  - Write all coefficients to 0x1000, then feed 8× 0x7FFF. Output 8 is 0x7FFF with `sat_flag` = 1.
  - Feed 8× 0x8000. Output is 0x8000 with `sat_flag` = 1.
- **Handshake timing and backpressure:**
  - Check `out_valid` rises 9 edges after accept and the sample period is 11 cycles.
  - Hold `out_ready` = 0 for 20 cycles: `y_out` is stable and `in_ready` = 0 throughout.
- **Coefficient write during MAC:** write is dropped, `coef_err` pulses once, and output matches the old coefficients. The same write issued in IDLE takes effect on the next sample.
- **Reset mid-MAC:** assert `rst_n` low at MAC cycle 4. Outputs show reset values immediately, coefficients return to defaults, and the next impulse reproduces the default impulse response.
